// File: rtl/simon_gen2.sv
// rtl/simon_gen2.sv - Simon-style memory game: enter, play back and repeat a growing pattern sequence.
module simon_gen2 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int SCORE_W = $clog2(DEPTH + 1)
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               level,
  input  logic [WIDTH-1:0]   pattern,
  output logic [WIDTH-1:0]   pattern_leds,
  output logic [2:0]         mode_leds,
  output logic [SCORE_W-1:0] score
);

  // Encodings double as the mode LED values.
  typedef enum logic [2:0] {
    S_INPUT    = 3'b001,
    S_PLAYBACK = 3'b010,
    S_REPEAT   = 3'b100,
    S_DONE     = 3'b111,
    S_WIN      = 3'b011
  } mode_t;

  mode_t              state_q, state_d;
  logic [SCORE_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               level_q;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic [WIDTH-1:0]   cur;
  logic               onehot;
  logic               valid;
  logic               last;
  logic               wr_en;

  assign cur    = mem[idx_q];
  assign onehot = (|pattern) && ((pattern & (pattern - WIDTH'(1))) == '0);
  assign valid  = level_q ? (|pattern) : onehot;
  assign last   = (SCORE_W'(idx_q) == (len_q - SCORE_W'(1)));
  assign wr_en  = (state_q == S_INPUT) && valid;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    case (state_q)
      S_INPUT: begin
        if (valid) begin
          len_d   = len_q + SCORE_W'(1);
          idx_d   = '0;
          state_d = S_PLAYBACK;
        end
      end
      S_PLAYBACK: begin
        if (last) begin
          idx_d   = '0;
          state_d = S_REPEAT;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_REPEAT: begin
        if (pattern == cur) begin
          if (last) begin
            score_d = score_q + SCORE_W'(1);
            idx_d   = '0;
            state_d = (len_q == SCORE_W'(DEPTH)) ? S_WIN : S_INPUT;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else begin
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE, S_WIN: begin
        idx_d = last ? '0 : idx_q + ADDR_W'(1);
      end
      default: state_d = S_INPUT;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= S_INPUT;
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      score_q <= score_d;
    end
  end

  // Difficulty is captured only while reset is held, so mid-game changes are ignored.
  always_ff @(posedge pclk) begin
    if (rst) level_q <= level;
  end

  // Sequence memory is deliberately not reset; entries are rewritten before being shown.
  always_ff @(posedge pclk) begin
    if (wr_en) mem[len_q[ADDR_W-1:0]] <= pattern;
  end

  assign mode_leds    = state_q;
  assign score        = score_q;
  assign pattern_leds = (state_q == S_INPUT || state_q == S_REPEAT) ? pattern : cur;

endmodule

// File: tb/tb_simon_gen2.sv
// tb/tb_simon_gen2.sv - Randomized self-checking bench for simon_gen2 with a queue-based game model.
module tb_simon_gen2;

  logic       pclk = 1'b0;
  logic       rst, level;
  logic [3:0] pattern;
  logic [3:0] pattern_leds;
  logic [2:0] mode_leds;
  logic [6:0] score;

  logic       rst2, level2;
  logic [3:0] pattern2;
  logic [3:0] pattern_leds2;
  logic [2:0] mode_leds2;
  logic [1:0] score2;

  int checks = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  simon_gen2 #(.WIDTH(4), .DEPTH(64)) dut (
    .pclk(pclk), .rst(rst), .level(level), .pattern(pattern),
    .pattern_leds(pattern_leds), .mode_leds(mode_leds), .score(score)
  );

  simon_gen2 #(.WIDTH(4), .DEPTH(2)) dut_win (
    .pclk(pclk), .rst(rst2), .level(level2), .pattern(pattern2),
    .pattern_leds(pattern_leds2), .mode_leds(mode_leds2), .score(score2)
  );

  task automatic tick;
    @(posedge pclk);
    @(negedge pclk);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    rst = 1'b1;
    level = lvl;
    tick();
    tick();
    rst = 1'b0;
    level = 1'($urandom);
    #1;
  endtask

  task automatic test_reset;
    pattern = 4'b0110;
    do_reset(1'b0);
    checks++;
    if (mode_leds !== 3'b001) begin failures++; $display("FAIL reset_mode got=%b exp=001", mode_leds); end
    checks++;
    if (score !== 7'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++;
    if (pattern_leds !== 4'b0110) begin failures++; $display("FAIL reset_leds got=%b exp=0110", pattern_leds); end
  endtask

  task automatic test_easy_round;
    do_reset(1'b0);
    pattern = 4'b0001;
    tick();
    checks++;
    if (mode_leds !== 3'b010) begin failures++; $display("FAIL easy_play_mode got=%b exp=010", mode_leds); end
    checks++;
    if (pattern_leds !== 4'b0001) begin failures++; $display("FAIL easy_play_leds got=%b exp=0001", pattern_leds); end
    pattern = 4'b0000;
    tick();
    checks++;
    if (mode_leds !== 3'b100) begin failures++; $display("FAIL easy_repeat_mode got=%b exp=100", mode_leds); end
    pattern = 4'b0001;
    tick();
    checks++;
    if (mode_leds !== 3'b001) begin failures++; $display("FAIL easy_win_round_mode got=%b exp=001", mode_leds); end
    checks++;
    if (score !== 7'd1) begin failures++; $display("FAIL easy_score got=%0d exp=1", score); end
  endtask

  // Continues the game left by test_easy_round: sequence holds 0001, score 1.
  task automatic test_invalid_entry;
    pattern = 4'b1010;
    tick();
    checks++;
    if (mode_leds !== 3'b001) begin failures++; $display("FAIL invalid_mode got=%b exp=001", mode_leds); end
    pattern = 4'b1000;
    tick();
    checks++;
    if (mode_leds !== 3'b010 || pattern_leds !== 4'b0001)
      begin failures++; $display("FAIL second_play0 got=%b/%b exp=010/0001", mode_leds, pattern_leds); end
    tick();
    checks++;
    if (mode_leds !== 3'b010 || pattern_leds !== 4'b1000)
      begin failures++; $display("FAIL second_play1 got=%b/%b exp=010/1000", mode_leds, pattern_leds); end
    tick();
    checks++;
    if (mode_leds !== 3'b100) begin failures++; $display("FAIL second_repeat got=%b exp=100", mode_leds); end
  endtask

  task automatic test_fail_done;
    pattern = 4'b0001;
    tick();
    pattern = 4'b0100;
    tick();
    checks++;
    if (mode_leds !== 3'b111 || score !== 7'd1)
      begin failures++; $display("FAIL done_entry got=%b/%0d exp=111/1", mode_leds, score); end
    checks++;
    if (pattern_leds !== 4'b0001) begin failures++; $display("FAIL done_led0 got=%b exp=0001", pattern_leds); end
    pattern = 4'b1111;
    tick();
    checks++;
    if (pattern_leds !== 4'b1000) begin failures++; $display("FAIL done_led1 got=%b exp=1000", pattern_leds); end
    tick();
    checks++;
    if (pattern_leds !== 4'b0001 || mode_leds !== 3'b111)
      begin failures++; $display("FAIL done_wrap got=%b/%b exp=0001/111", pattern_leds, mode_leds); end
  endtask

  task automatic test_hard_level;
    do_reset(1'b0);
    pattern = 4'b1001;
    tick();
    checks++;
    if (mode_leds !== 3'b001) begin failures++; $display("FAIL easy_rejects_1001 got=%b exp=001", mode_leds); end
    do_reset(1'b1);
    level = 1'b0;
    tick();
    checks++;
    if (mode_leds !== 3'b010) begin failures++; $display("FAIL hard_accepts_1001 got=%b exp=010", mode_leds); end
    checks++;
    if (pattern_leds !== 4'b1001) begin failures++; $display("FAIL hard_play_leds got=%b exp=1001", pattern_leds); end
  endtask

  task automatic test_async_reset;
    do_reset(1'b0);
    pattern = 4'b0001;
    tick();
    tick();
    tick();
    pattern = 4'b0010;
    tick();
    checks++;
    if (mode_leds !== 3'b010 || score !== 7'd1)
      begin failures++; $display("FAIL async_pre got=%b/%0d exp=010/1", mode_leds, score); end
    pattern = 4'b0000;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mode_leds !== 3'b001 || score !== 7'd0)
      begin failures++; $display("FAIL async_reset got=%b/%0d exp=001/0", mode_leds, score); end
    rst = 1'b0;
    tick();
    checks++;
    if (mode_leds !== 3'b001 || pattern_leds !== 4'b0000)
      begin failures++; $display("FAIL async_after got=%b/%b exp=001/0000", mode_leds, pattern_leds); end
  endtask

  task automatic test_win;
    logic [3:0] seq2 [2];
    seq2[0] = 4'b0010;
    seq2[1] = 4'b0100;
    rst2 = 1'b1; level2 = 1'b0; pattern2 = 4'b0000;
    tick(); tick();
    rst2 = 1'b0; #1;
    pattern2 = seq2[0]; tick();
    pattern2 = 4'b0000; tick();
    pattern2 = seq2[0]; tick();
    checks++;
    if (mode_leds2 !== 3'b001 || score2 !== 2'd1)
      begin failures++; $display("FAIL win_round1 got=%b/%0d exp=001/1", mode_leds2, score2); end
    pattern2 = seq2[1]; tick();
    pattern2 = 4'b0000; tick(); tick();
    pattern2 = seq2[0]; tick();
    pattern2 = seq2[1]; tick();
    checks++;
    if (mode_leds2 !== 3'b011 || score2 !== 2'd2)
      begin failures++; $display("FAIL win_entry got=%b/%0d exp=011/2", mode_leds2, score2); end
    for (int k = 0; k < 4; k++) begin
      pattern2 = 4'($urandom);
      #1;
      checks++;
      if (pattern_leds2 !== seq2[k % 2] || mode_leds2 !== 3'b011)
        begin failures++; $display("FAIL win_wrap%0d got=%b/%b exp=%b/011", k, pattern_leds2, mode_leds2, seq2[k % 2]); end
      tick();
    end
  endtask

  // Scripted random games: expected behaviour is derived from the game rules over a queue.
  task automatic test_random_games;
    logic [3:0] seq [$];
    logic [3:0] p, g;
    logic       lvl;
    int         exp_score;
    bit         lost;
    for (int game = 0; game < 6; game++) begin
      lvl = 1'($urandom);
      pattern = 4'b0000;
      do_reset(lvl);
      seq.delete();
      exp_score = 0;
      lost = 0;
      for (int round = 0; round < 10 && !lost; round++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (lvl) p = 4'b0000;
          else begin
            p = 4'($urandom);
            while (p == 4'b0001 || p == 4'b0010 || p == 4'b0100 || p == 4'b1000) p = 4'($urandom);
          end
          pattern = p;
          tick();
          checks++;
          if (mode_leds !== 3'b001)
            begin failures++; $display("FAIL rnd_invalid g%0d got=%b exp=001 pat=%b", game, mode_leds, p); end
        end
        p = lvl ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
        pattern = p;
        #1;
        checks++;
        if (pattern_leds !== p) begin failures++; $display("FAIL rnd_input_leds got=%b exp=%b", pattern_leds, p); end
        tick();
        seq.push_back(p);
        pattern = 4'($urandom);
        for (int i = 0; i < seq.size(); i++) begin
          checks++;
          if (mode_leds !== 3'b010 || pattern_leds !== seq[i])
            begin failures++; $display("FAIL rnd_play i=%0d got=%b/%b exp=010/%b", i, mode_leds, pattern_leds, seq[i]); end
          tick();
        end
        for (int i = 0; i < seq.size() && !lost; i++) begin
          g = seq[i];
          if ($urandom_range(0, 15) == 0) begin
            while (g == seq[i]) g = 4'($urandom);
            lost = 1;
          end
          pattern = g;
          #1;
          checks++;
          if (mode_leds !== 3'b100 || pattern_leds !== g)
            begin failures++; $display("FAIL rnd_repeat i=%0d got=%b/%b exp=100/%b", i, mode_leds, pattern_leds, g); end
          tick();
        end
        if (!lost) begin
          exp_score++;
          checks++;
          if (mode_leds !== 3'b001 || score !== 7'(exp_score))
            begin failures++; $display("FAIL rnd_round got=%b/%0d exp=001/%0d", mode_leds, score, exp_score); end
        end
      end
      if (lost) begin
        for (int k = 0; k < seq.size() + 2; k++) begin
          pattern = 4'($urandom);
          #1;
          checks++;
          if (mode_leds !== 3'b111 || score !== 7'(exp_score) || pattern_leds !== seq[k % seq.size()])
            begin failures++; $display("FAIL rnd_done k=%0d got=%b/%0d/%b exp=111/%0d/%b", k, mode_leds, score, pattern_leds, exp_score, seq[k % seq.size()]); end
          tick();
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; level = 1'b0; pattern = 4'b0000;
    rst2 = 1'b1; level2 = 1'b0; pattern2 = 4'b0000;
    @(negedge pclk);
    test_reset();
    test_easy_round();
    test_invalid_entry();
    test_fail_done();
    test_hard_level();
    test_async_reset();
    test_win();
    test_random_games();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
